// File: rtl/mcu_reg_bridge_if.sv
// mcu_reg_bridge_if
//   Groups the MCU SPI pins that connect the bridge to the MCU.
//   master : the MCU side, which drives chip select, clock and MOSI
//   slave  : the bridge side, which drives MISO and the MISO output enable
//   spi_cs_n    chip select, active-low, async to clk
//   spi_sck     SPI clock (mode 0), async to clk
//   spi_mosi    data from the MCU
//   spi_miso    data to the MCU
//   spi_miso_oe high while the bridge sees chip select asserted
interface mcu_reg_bridge_if;
    logic spi_cs_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_cs_n,
        output spi_sck,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/mcu_reg_bridge.sv
// mcu_reg_bridge
//   SPI slave (mode 0, MSB first) between the MCU and the mapper mux. The SPI pins
//   are oversampled in the clk domain. Write frames {1,xxx,addr} + 16 data bits are
//   published on wr_reg/wr_reg_addr, followed one clk later by a wr_reg_changed toggle.
//   Publishes are spaced by at least HOLD_CYCLES clk cycles so the m2-domain consumer
//   can capture each one; a single pending slot absorbs writes that arrive during the
//   hold (latest wins, sticky overrun flag). Read frames {0,xxx,addr} return 32 bits.
//   clk            system clock, SCK must be <= clk/8
//   cpu_reset      asynchronous active-high reset
//   spi            SPI pins (slave modport)
//   wr_reg         last published register value
//   wr_reg_addr    last published register address
//   wr_reg_changed toggles once per published write
//   status_reg     status word from the mapper mux, returned at address 0
module mcu_reg_bridge #(
    parameter int unsigned HOLD_CYCLES = 512,
    parameter logic [31:0] ID_WORD     = 32'h46434152
) (
    input  logic                 clk,
    input  logic                 cpu_reset,
    mcu_reg_bridge_if.slave      spi,
    output logic [15:0]          wr_reg,
    output logic [3:0]           wr_reg_addr,
    output logic                 wr_reg_changed,
    input  logic [31:0]          status_reg
);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, WDATA, RDATA, DONE} state_t;

    logic [2:0]    cs_q;
    logic [2:0]    sck_q;
    logic [1:0]    mosi_q;
    state_t        state_q, state_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic [14:0]   sh_q, sh_d;
    logic [3:0]    addr_q, addr_d;
    logic [31:0]   rd_shift_q, rd_shift_d;
    logic          miso_q, miso_d;
    logic          oe_q, oe_d;
    logic          pend_valid_q, pend_valid_d;
    logic [15:0]   pend_data_q, pend_data_d;
    logic [3:0]    pend_addr_q, pend_addr_d;
    logic          ov_q, ov_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tog_pend_q, tog_pend_d;
    logic [15:0]   wr_reg_q, wr_reg_d;
    logic [3:0]    wr_addr_q, wr_addr_d;
    logic          changed_q, changed_d;

    logic          cs_s, cs_rise, cs_fall, rise, fall, mosi_s;
    logic [3:0]    cmd_addr;
    logic [15:0]   wr_word;
    logic          wr_done, rd_clr, fire, ov_set;

    assign cs_s     = cs_q[1];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign rise     = sck_q[1] & ~sck_q[2];
    assign fall     = ~sck_q[1] & sck_q[2];
    assign mosi_s   = mosi_q[1];
    assign cmd_addr = {sh_q[2:0], mosi_s};
    assign wr_word  = {sh_q, mosi_s};

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        sh_d         = sh_q;
        addr_d       = addr_q;
        rd_shift_d   = rd_shift_q;
        miso_d       = 1'b0;
        oe_d         = ~cs_s;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_addr_d  = pend_addr_q;
        ov_d         = ov_q;
        hold_d       = hold_q;
        tog_pend_d   = tog_pend_q;
        wr_reg_d     = wr_reg_q;
        wr_addr_d    = wr_addr_q;
        changed_d    = changed_q;
        wr_done      = 1'b0;
        rd_clr       = 1'b0;
        ov_set       = 1'b0;

        if (cs_rise && (state_q inside {CMD, WDATA, RDATA, DONE})) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                WAIT_CS: if (cs_s) state_d = IDLE;
                IDLE: begin
                    if (cs_fall) begin
                        bitcnt_d = '0;
                        state_d  = CMD;
                    end
                end
                CMD: begin
                    if (rise) begin
                        sh_d     = {sh_q[13:0], mosi_s};
                        bitcnt_d = bitcnt_q + 6'd1;
                        if (bitcnt_q == 6'd7) begin
                            // sh_q[6] holds the first (rw) bit of the command byte
                            addr_d   = cmd_addr;
                            bitcnt_d = '0;
                            if (sh_q[6]) begin
                                state_d = WDATA;
                            end else begin
                                state_d = RDATA;
                                case (cmd_addr)
                                    4'h0: rd_shift_d = status_reg;
                                    4'h1: begin
                                        rd_shift_d = {30'd0, pend_valid_q, ov_q};
                                        rd_clr     = 1'b1;
                                    end
                                    4'hF: rd_shift_d = ID_WORD;
                                    default: rd_shift_d = '0;
                                endcase
                            end
                        end
                    end
                end
                WDATA: begin
                    if (rise) begin
                        sh_d     = {sh_q[13:0], mosi_s};
                        bitcnt_d = bitcnt_q + 6'd1;
                        if (bitcnt_q == 6'd15) begin
                            wr_done = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                RDATA: begin
                    miso_d = miso_q;
                    // The last bit stays on MISO until the MCU samples it on the
                    // following rise; only then is the frame complete.
                    if (fall && bitcnt_q != 6'd32) begin
                        miso_d     = rd_shift_q[31];
                        rd_shift_d = {rd_shift_q[30:0], 1'b0};
                        bitcnt_d   = bitcnt_q + 6'd1;
                    end else if (rise && bitcnt_q == 6'd32) begin
                        miso_d  = 1'b0;
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end

        // Publish: slot -> outputs in cycle T+1, toggle and hold reload in T+2.
        fire = pend_valid_q && (hold_q == '0) && !tog_pend_q;
        if (fire) begin
            wr_reg_d     = pend_data_q;
            wr_addr_d    = pend_addr_q;
            pend_valid_d = 1'b0;
            tog_pend_d   = 1'b1;
        end
        if (tog_pend_q) begin
            changed_d  = ~changed_q;
            tog_pend_d = 1'b0;
            hold_d     = HOLD_RELOAD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end
        // A write landing in the publish cycle refills the just-emptied slot.
        if (wr_done) begin
            pend_data_d  = wr_word;
            pend_addr_d  = addr_q;
            pend_valid_d = 1'b1;
            ov_set       = pend_valid_q && !fire;
        end
        if (rd_clr) ov_d = 1'b0;
        if (ov_set) ov_d = 1'b1;
    end

    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            // CS sync resets to "asserted" so a frame in flight is ignored until
            // the MCU actually releases chip select.
            cs_q         <= '0;
            sck_q        <= '0;
            mosi_q       <= '0;
            state_q      <= WAIT_CS;
            bitcnt_q     <= '0;
            sh_q         <= '0;
            addr_q       <= '0;
            rd_shift_q   <= '0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_addr_q  <= '0;
            ov_q         <= 1'b0;
            hold_q       <= '0;
            tog_pend_q   <= 1'b0;
            wr_reg_q     <= '0;
            wr_addr_q    <= '0;
            changed_q    <= 1'b0;
        end else begin
            cs_q         <= {cs_q[1:0], spi.spi_cs_n};
            sck_q        <= {sck_q[1:0], spi.spi_sck};
            mosi_q       <= {mosi_q[0], spi.spi_mosi};
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            sh_q         <= sh_d;
            addr_q       <= addr_d;
            rd_shift_q   <= rd_shift_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_addr_q  <= pend_addr_d;
            ov_q         <= ov_d;
            hold_q       <= hold_d;
            tog_pend_q   <= tog_pend_d;
            wr_reg_q     <= wr_reg_d;
            wr_addr_q    <= wr_addr_d;
            changed_q    <= changed_d;
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = oe_q;
    assign wr_reg          = wr_reg_q;
    assign wr_reg_addr     = wr_addr_q;
    assign wr_reg_changed  = changed_q;
endmodule

// File: tb/tb_mcu_reg_bridge.sv
// tb_mcu_reg_bridge
//   Directed bench for mcu_reg_bridge: SCK = clk/8, stimulus on the clk falling edge,
//   a negedge monitor logging every publish (data change and toggle cycles).
module tb_mcu_reg_bridge;
    localparam int HOLD = 512;

    logic        clk = 1'b0;
    logic        cpu_reset;
    logic [15:0] wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_reg_changed;
    logic [31:0] status_reg;

    mcu_reg_bridge_if bus();

    mcu_reg_bridge #(.HOLD_CYCLES(HOLD), .ID_WORD(32'h46434152)) dut (
        .clk            (clk),
        .cpu_reset      (cpu_reset),
        .spi            (bus),
        .wr_reg         (wr_reg),
        .wr_reg_addr    (wr_reg_addr),
        .wr_reg_changed (wr_reg_changed),
        .status_reg     (status_reg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] rx;

    always @(posedge clk) cyc <= cyc + 1;

    int          tog_cyc[$];
    int          data_cyc[$];
    logic [15:0] tog_data[$];
    logic [3:0]  tog_addr[$];
    logic        prev_chg;
    logic [19:0] prev_out;

    always @(negedge clk) begin
        if (cpu_reset !== 1'b0) begin
            prev_chg = wr_reg_changed;
            prev_out = {wr_reg, wr_reg_addr};
        end else begin
            if ({wr_reg, wr_reg_addr} !== prev_out) data_cyc.push_back(cyc);
            if (wr_reg_changed !== prev_chg) begin
                tog_cyc.push_back(cyc);
                tog_data.push_back(wr_reg);
                tog_addr.push_back(wr_reg_addr);
            end
            prev_chg = wr_reg_changed;
            prev_out = {wr_reg, wr_reg_addr};
        end
    end

    task automatic clear_log();
        tog_cyc.delete();
        data_cyc.delete();
        tog_data.delete();
        tog_addr.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic b);
        bus.spi_mosi = b;
        #40;
        rx = {rx[30:0], bus.spi_miso};
        bus.spi_sck = 1'b1;
        #40;
        bus.spi_sck = 1'b0;
    endtask

    task automatic cs_begin();
        bus.spi_cs_n = 1'b0;
        #40;
    endtask

    task automatic cs_end();
        #40;
        bus.spi_cs_n = 1'b1;
        #160;
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        for (int i = 7; i >= 0; i--) sck_bit(cmd[i]);
    endtask

    task automatic spi_write(input logic [7:0] cmd, input logic [15:0] d);
        cs_begin();
        send_cmd(cmd);
        for (int i = 15; i >= 0; i--) sck_bit(d[i]);
        cs_end();
    endtask

    task automatic spi_read(input logic [7:0] cmd, output logic [31:0] r);
        cs_begin();
        send_cmd(cmd);
        for (int i = 0; i < 32; i++) sck_bit(1'b0);
        r = rx;
        cs_end();
    endtask

    task automatic wait_tog(input int n, input int budget, output bit ok);
        int k = 0;
        while (tog_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (tog_cyc.size() >= n);
    endtask

    task automatic test_reset();
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        status_reg   = '0;
        cpu_reset    = 1'b1;
        idle_cycles(5);
        n_checks++; if (wr_reg !== 16'h0) $display("FAIL reset_wr_reg got=%h exp=0000", wr_reg); else n_pass++;
        n_checks++; if (wr_reg_addr !== 4'h0) $display("FAIL reset_addr got=%h exp=0", wr_reg_addr); else n_pass++;
        n_checks++; if (wr_reg_changed !== 1'b0) $display("FAIL reset_changed got=%b exp=0", wr_reg_changed); else n_pass++;
        n_checks++; if (bus.spi_miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", bus.spi_miso); else n_pass++;
        n_checks++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", bus.spi_miso_oe); else n_pass++;
        cpu_reset = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_single_write();
        bit ok;
        int dc;
        clear_log();
        spi_write(8'h80, 16'h1A25);
        wait_tog(1, 100, ok);
        n_checks++; if (!ok) $display("FAIL w1_toggle got=none exp=1 toggle"); else n_pass++;
        if (ok) begin
            n_checks++; if (tog_data[0] !== 16'h1A25) $display("FAIL w1_data got=%h exp=1a25", tog_data[0]); else n_pass++;
            n_checks++; if (tog_addr[0] !== 4'h0) $display("FAIL w1_addr got=%h exp=0", tog_addr[0]); else n_pass++;
            dc = (data_cyc.size() > 0) ? data_cyc[0] : -1;
            n_checks++; if (dc !== tog_cyc[0] - 1) $display("FAIL w1_data_lead got=%0d exp=%0d", dc, tog_cyc[0] - 1); else n_pass++;
        end
        idle_cycles(60);
        n_checks++; if (tog_cyc.size() !== 1) $display("FAIL w1_toggle_count got=%0d exp=1", tog_cyc.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] r;
        idle_cycles(HOLD + 20);
        clear_log();
        spi_write(8'h81, 16'h1111);
        spi_write(8'h80, 16'h2222);
        spi_write(8'h80, 16'h3333);
        wait_tog(2, 1200, ok);
        n_checks++; if (!ok) $display("FAIL b2b_toggles got=%0d exp=2", tog_cyc.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (tog_data[0] !== 16'h1111 || tog_addr[0] !== 4'h1)
                $display("FAIL b2b_first got=%h@%h exp=1111@1", tog_data[0], tog_addr[0]); else n_pass++;
            n_checks++; if (tog_data[1] !== 16'h3333 || tog_addr[1] !== 4'h0)
                $display("FAIL b2b_latest got=%h@%h exp=3333@0", tog_data[1], tog_addr[1]); else n_pass++;
            n_checks++; if (tog_cyc[1] - tog_cyc[0] < HOLD)
                $display("FAIL b2b_spacing got=%0d exp>=%0d", tog_cyc[1] - tog_cyc[0], HOLD); else n_pass++;
        end
        idle_cycles(HOLD + 20);
        n_checks++; if (tog_cyc.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", tog_cyc.size()); else n_pass++;
        spi_read(8'h01, r);
        n_checks++; if (r !== 32'h1) $display("FAIL b2b_flags got=%h exp=00000001", r); else n_pass++;
        spi_read(8'h01, r);
        n_checks++; if (r !== 32'h0) $display("FAIL b2b_flags_clr got=%h exp=00000000", r); else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] r;
        status_reg = 32'h0000_02C3;
        cs_begin();
        n_checks++; if (bus.spi_miso_oe !== 1'b1) $display("FAIL rd_oe_on got=%b exp=1", bus.spi_miso_oe); else n_pass++;
        send_cmd(8'h00);
        for (int i = 0; i < 4; i++) sck_bit(1'b0);
        status_reg = 32'hFFFF_FFFF;
        for (int i = 0; i < 28; i++) sck_bit(1'b0);
        r = rx;
        cs_end();
        n_checks++; if (r !== 32'h0000_02C3) $display("FAIL rd_status got=%h exp=000002c3", r); else n_pass++;
        n_checks++; if (bus.spi_miso_oe !== 1'b0) $display("FAIL rd_oe_off got=%b exp=0", bus.spi_miso_oe); else n_pass++;
        n_checks++; if (bus.spi_miso !== 1'b0) $display("FAIL rd_miso_idle got=%b exp=0", bus.spi_miso); else n_pass++;
        spi_read(8'h0F, r);
        n_checks++; if (r !== 32'h4643_4152) $display("FAIL rd_id got=%h exp=46434152", r); else n_pass++;
        spi_read(8'h3F, r);
        n_checks++; if (r !== 32'h4643_4152) $display("FAIL rd_id_dontcare got=%h exp=46434152", r); else n_pass++;
        spi_read(8'h07, r);
        n_checks++; if (r !== 32'h0) $display("FAIL rd_unmapped got=%h exp=00000000", r); else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        logic [31:0] r;
        logic [15:0] d;
        d = 16'hBEEF;
        idle_cycles(HOLD + 20);
        clear_log();
        cs_begin();
        send_cmd(8'h82);
        for (int i = 15; i >= 6; i--) sck_bit(d[i]);
        cs_end();
        idle_cycles(100);
        n_checks++; if (tog_cyc.size() !== 0) $display("FAIL abort_toggle got=%0d exp=0", tog_cyc.size()); else n_pass++;
        n_checks++; if (wr_reg !== 16'h3333 || wr_reg_addr !== 4'h0)
            $display("FAIL abort_outputs got=%h@%h exp=3333@0", wr_reg, wr_reg_addr); else n_pass++;
        spi_read(8'h01, r);
        n_checks++; if (r !== 32'h0) $display("FAIL abort_flags got=%h exp=00000000", r); else n_pass++;
        spi_write(8'h82, 16'hBEEF);
        wait_tog(1, 100, ok);
        n_checks++; if (!ok || tog_data[0] !== 16'hBEEF || tog_addr[0] !== 4'h2)
            $display("FAIL abort_next got=%0d toggles exp=beef@2", tog_cyc.size()); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [15:0] d;
        d = 16'hC0DE;
        idle_cycles(HOLD + 20);
        clear_log();
        cs_begin();
        send_cmd(8'h83);
        for (int i = 15; i >= 11; i--) sck_bit(d[i]);
        cpu_reset = 1'b1;
        idle_cycles(3);
        n_checks++; if (wr_reg !== 16'h0 || wr_reg_addr !== 4'h0)
            $display("FAIL mrst_outputs got=%h@%h exp=0000@0", wr_reg, wr_reg_addr); else n_pass++;
        n_checks++; if (wr_reg_changed !== 1'b0) $display("FAIL mrst_changed got=%b exp=0", wr_reg_changed); else n_pass++;
        n_checks++; if (bus.spi_miso !== 1'b0 || bus.spi_miso_oe !== 1'b0)
            $display("FAIL mrst_miso got=%b/%b exp=0/0", bus.spi_miso, bus.spi_miso_oe); else n_pass++;
        cpu_reset = 1'b0;
        idle_cycles(2);
        for (int i = 10; i >= 0; i--) sck_bit(d[i]);
        cs_end();
        idle_cycles(50);
        n_checks++; if (tog_cyc.size() !== 0 || wr_reg !== 16'h0)
            $display("FAIL mrst_ignored got=%0d toggles wr_reg=%h exp=0 toggles wr_reg=0000", tog_cyc.size(), wr_reg); else n_pass++;
        spi_write(8'h84, 16'h5A5A);
        wait_tog(1, 100, ok);
        n_checks++; if (!ok || tog_data[0] !== 16'h5A5A || tog_addr[0] !== 4'h4)
            $display("FAIL mrst_next got=%0d toggles exp=5a5a@4", tog_cyc.size()); else n_pass++;
        n_checks++; if (wr_reg_changed !== 1'b1) $display("FAIL mrst_changed_after got=%b exp=1", wr_reg_changed); else n_pass++;
    endtask

    task automatic test_publish_collision();
        bit ok;
        int p;
        logic [31:0] r;
        logic [15:0] d;
        d = 16'hCCCC;
        idle_cycles(HOLD + 20);
        clear_log();
        spi_write(8'h85, 16'hAAAA);
        wait_tog(1, 100, ok);
        n_checks++; if (!ok) $display("FAIL coll_first got=none exp=1 toggle"); else n_pass++;
        p = ok ? tog_cyc[0] : cyc;
        spi_write(8'h86, 16'hBBBB);
        // Hold expires in cycle p+HOLD-1; the 24th SCK rise driven 192 cycles after
        // CS falls is seen by the bridge 2 cycles later, landing in that same cycle.
        while (cyc < p + HOLD - 195) @(negedge clk);
        n_checks++; if (cyc !== p + HOLD - 195) $display("FAIL coll_align got=%0d exp=%0d", cyc, p + HOLD - 195); else n_pass++;
        cs_begin();
        send_cmd(8'h87);
        for (int i = 15; i >= 0; i--) sck_bit(d[i]);
        cs_end();
        wait_tog(3, 1200, ok);
        n_checks++; if (!ok) $display("FAIL coll_toggles got=%0d exp=3", tog_cyc.size()); else n_pass++;
        if (ok) begin
            n_checks++; if (tog_data[1] !== 16'hBBBB || tog_addr[1] !== 4'h6)
                $display("FAIL coll_old got=%h@%h exp=bbbb@6", tog_data[1], tog_addr[1]); else n_pass++;
            n_checks++; if (tog_data[2] !== 16'hCCCC || tog_addr[2] !== 4'h7)
                $display("FAIL coll_new got=%h@%h exp=cccc@7", tog_data[2], tog_addr[2]); else n_pass++;
        end
        spi_read(8'h01, r);
        n_checks++; if (r !== 32'h0) $display("FAIL coll_flags got=%h exp=00000000", r); else n_pass++;
    endtask

    initial begin
        cpu_reset    = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        status_reg   = '0;
        rx           = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_abort();
        test_reset_midframe();
        test_publish_collision();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
